cache_miss_controller: RTL and testbench
========================================

Name: cache_miss_controller

Overview:
- Sequencing FSM between the CPU load/store port, the direct-mapped cache with victim cache, and main memory.
- On load miss: swaps the block in from the victim cache, or refills it from memory one word beat at a time, then re-looks-up.
- Stores are write-through, no-write-allocate.
- Stalls the single-cycle core until the access completes.

Parameters:
- Width, 32, address/data width.
- BlockSize, 16, cache block size in bytes; multiple of 4; refill beats = BlockSize/4.
- CntWidth, 16, width of the hit/miss performance counters (wrap-around).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- Cpu_Req  in  1  access valid; address, data and mode held stable while Cpu_Stall=1.
- Cpu_WE  in  1  1=store, 0=load.
- Cpu_Mode  in  3  load/store mode, same encoding as the cache (000 LB … 111 SW).
- Cpu_Address  in  Width  byte address.
- Cpu_Data_IN  in  Width  store data.
- Cpu_Stall  out  1  combinational; =Cpu_Req & !Cpu_Done.
- Cpu_Done  out  1  one-cycle pulse; access completes this cycle.
- Cache_Hit  in  1  cache tag-match for Cpu_Address.
- Victim_Hit  in  1  victim cache holds the block.
- Cache_EN_W  out  1  cache write strobe, store hit.
- Cache_Swap  out  1  promote victim block into the cache.
- Cache_Fill  out  1  write one refill word.
- Cache_Fill_Beat  out  clog2(BlockSize/4)  word index in block.
- Cache_Fill_Data  out  Width  refill word.
- Mem_Req  out  1  memory request valid.
- Mem_WE  out  1  memory write.
- Mem_Addr  out  Width  memory address.
- Mem_WData  out  Width  store data.
- Mem_Mode  out  3  store mode forwarded.
- Mem_Ack  in  1  request accepted.
- Mem_RValid  in  1  read data valid.
- Mem_RData  in  Width  read data.
- Hit_Count, Miss_Count  out  CntWidth  performance counters.

Behaviour:
States: IDLE, SWAP, RD_REQ, RD_WAIT, RETRY, WR_REQ.

Reset (rst_n=0 at posedge, any state):
- state→IDLE, beat counter=0, counters=0.
- All outputs 0 (Cpu_Stall follows Cpu_Req).
- Any in-flight memory transaction is abandoned; Mem_RValid arriving afterwards is ignored in IDLE.

IDLE with Cpu_Req=1:
- Load, Cache_Hit=1: Cpu_Done=1 same cycle (zero-stall); Hit_Count++; stay IDLE.
- Load, Cache_Hit=0, Victim_Hit=1: →SWAP; Miss_Count++.
- Load, both 0: →RD_REQ, beat=0; Miss_Count++.
- Store, Cache_Hit=1: Cache_EN_W=1 this cycle; Hit_Count++; →WR_REQ.
- Store, Cache_Hit=0: →WR_REQ; Miss_Count++; cache untouched.

SWAP:
- Cache_Swap=1 for exactly one cycle.
- →RETRY.

RD_REQ:
- Mem_Req=1, Mem_WE=0.
- Mem_Addr = {Cpu_Address[Width-1:clog2(BlockSize)], beat, 2'b00}.
- Held until Mem_Ack → RD_WAIT.

RD_WAIT, on Mem_RValid:
- Cache_Fill=1, Cache_Fill_Beat=beat, Cache_Fill_Data=Mem_RData.
- Last beat: →RETRY, beat=0.
- Otherwise: beat++, →RD_REQ.
- Mem_Ack and Mem_RValid in the same cycle is legal: RD_REQ→RD_WAIT, and data is consumed next cycle only if still valid. Memory holds RValid until consumed.

RETRY:
- Re-evaluate exactly as in IDLE, counters not incremented.
- Expected Cache_Hit=1 → Cpu_Done, →IDLE.
- A second miss re-enters the miss path, e.g. if the swap victimised the requested block.

WR_REQ:
- Mem_Req=1, Mem_WE=1, Mem_Addr=Cpu_Address, Mem_WData=Cpu_Data_IN, Mem_Mode=Cpu_Mode.
- On Mem_Ack: Cpu_Done=1, →IDLE.

Other rules:
- Cpu_Req dropping while not in IDLE is a protocol violation; the FSM completes its sequence regardless.
- Counters wrap at 2^CntWidth.
- Mem_Mode is 0 outside WR_REQ.

Decomposition:
- Shared package cache_pkg:
  - state enum cache_ctrl_state_t.
  - Mode encodings: LB, LH, LW, LBU, LHU, SB, SHW, SW.
  - clog2 function.
- One sub-module: cache_refill_counter (beat counter with last-beat flag, clear/increment).

Test Plan:
- Load hit: Cpu_Req=1, WE=0, Cache_Hit=1 → Cpu_Done=1 same cycle, Cpu_Stall=0, Hit_Count=1, no Mem_Req.
- Victim hit: load 0x0000_1234, Hit=0, Victim_Hit=1, then Hit=1 → Cache_Swap 1 cycle, Cpu_Done in cycle 3, Miss_Count=1.
- Memory refill, BlockSize=16: load 0x0000_1238 miss, Mem_Ack 1 cycle after each Req, RData 0xA0..0xA3 → Mem_Addr 0x1230/4/8/C, Fill beats 0..3 with matching data, Cpu_Done after RETRY, Stall high throughout.
- Store: hit at 0x40 data 0xDEADBEEF SW → Cache_EN_W pulse, Mem write 0x40/0xDEADBEEF/111, Done on Ack. Miss variant → no Cache_EN_W, same Mem write.
- Reset mid-refill: rst_n=0 in RD_WAIT beat 2 → next cycle IDLE, all outputs 0, counters 0. Late Mem_RValid → no Cache_Fill.
- Counter wrap, CntWidth=4: 16 load hits → Hit_Count returns to 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache miss controller: FSM state encoding,
// load/store mode encodings and a constant-foldable clog2.
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SWAP    = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_RETRY   = 3'd4,
    S_WR_REQ  = 3'd5
  } cache_ctrl_state_t;

  localparam logic [2:0] MODE_LB  = 3'b000;
  localparam logic [2:0] MODE_LH  = 3'b001;
  localparam logic [2:0] MODE_LW  = 3'b010;
  localparam logic [2:0] MODE_LBU = 3'b011;
  localparam logic [2:0] MODE_LHU = 3'b100;
  localparam logic [2:0] MODE_SB  = 3'b101;
  localparam logic [2:0] MODE_SHW = 3'b110;
  localparam logic [2:0] MODE_SW  = 3'b111;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_refill_counter.sv
// Word-beat counter for block refills; clear has priority over increment and
// last_o flags the final beat of the block.
module cache_refill_counter #(
  parameter int Beats = 4,
  parameter int BeatW = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [BeatW-1:0] beat_o,
  output logic             last_o
);

  logic [BeatW-1:0] beat_q;
  logic [BeatW-1:0] beat_d;

  always_comb begin
    beat_d = beat_q;
    if (clr_i) begin
      beat_d = '0;
    end else if (inc_i) begin
      beat_d = beat_q + BeatW'(1);
    end else begin
      beat_d = beat_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  assign beat_o = beat_q;
  assign last_o = (beat_q == BeatW'(Beats - 1));

endmodule

// File: rtl/cache_miss_controller.sv
// Miss-handling FSM between a stalling single-cycle core, a direct-mapped cache
// with victim cache, and word-wide main memory. Stores are write-through.
module cache_miss_controller
  import cache_pkg::*;
#(
  parameter int Width     = 32,
  parameter int BlockSize = 16,
  parameter int CntWidth  = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                Cpu_Req,
  input  logic                                Cpu_WE,
  input  logic [2:0]                          Cpu_Mode,
  input  logic [Width-1:0]                    Cpu_Address,
  input  logic [Width-1:0]                    Cpu_Data_IN,
  output logic                                Cpu_Stall,
  output logic                                Cpu_Done,
  input  logic                                Cache_Hit,
  input  logic                                Victim_Hit,
  output logic                                Cache_EN_W,
  output logic                                Cache_Swap,
  output logic                                Cache_Fill,
  output logic [((clog2(BlockSize/4) > 0) ? clog2(BlockSize/4) : 1)-1:0] Cache_Fill_Beat,
  output logic [Width-1:0]                    Cache_Fill_Data,
  output logic                                Mem_Req,
  output logic                                Mem_WE,
  output logic [Width-1:0]                    Mem_Addr,
  output logic [Width-1:0]                    Mem_WData,
  output logic [2:0]                          Mem_Mode,
  input  logic                                Mem_Ack,
  input  logic                                Mem_RValid,
  input  logic [Width-1:0]                    Mem_RData,
  output logic [CntWidth-1:0]                 Hit_Count,
  output logic [CntWidth-1:0]                 Miss_Count
);

  localparam int OffW  = clog2(BlockSize);
  localparam int Beats = BlockSize / 4;
  localparam int BeatW = (clog2(Beats) > 0) ? clog2(Beats) : 1;

  cache_ctrl_state_t state_q, state_d;
  logic [CntWidth-1:0] hit_q, miss_q;
  logic [BeatW-1:0]    beat_s;
  logic                last_s, beat_clr_s, beat_inc_s, hit_inc_s, miss_inc_s;
  logic                eval_s, first_s;
  logic [Width-1:0]    blk_addr_s;

  // RETRY re-evaluates unconditionally; only the first look-up is counted.
  assign first_s    = (state_q == S_IDLE);
  assign eval_s     = (first_s && Cpu_Req) || (state_q == S_RETRY);
  assign blk_addr_s = {Cpu_Address[Width-1:OffW], {OffW{1'b0}}} | (Width'(beat_s) << 2);

  cache_refill_counter #(.Beats(Beats), .BeatW(BeatW)) u_beat (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (beat_clr_s),
    .inc_i  (beat_inc_s),
    .beat_o (beat_s),
    .last_o (last_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      if (hit_inc_s)  hit_q  <= hit_q + CntWidth'(1);
      if (miss_inc_s) miss_q <= miss_q + CntWidth'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_RETRY: begin
        if (!eval_s)          state_d = S_IDLE;
        else if (Cpu_WE)      state_d = S_WR_REQ;
        else if (Cache_Hit)   state_d = S_IDLE;
        else if (Victim_Hit)  state_d = S_SWAP;
        else                  state_d = S_RD_REQ;
      end
      S_SWAP:    state_d = S_RETRY;
      S_RD_REQ:  state_d = Mem_Ack ? S_RD_WAIT : S_RD_REQ;
      S_RD_WAIT: begin
        if (!Mem_RValid)  state_d = S_RD_WAIT;
        else if (last_s)  state_d = S_RETRY;
        else              state_d = S_RD_REQ;
      end
      S_WR_REQ:  state_d = Mem_Ack ? S_IDLE : S_WR_REQ;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Cpu_Done        = 1'b0;
    Cache_EN_W      = 1'b0;
    Cache_Swap      = 1'b0;
    Cache_Fill      = 1'b0;
    Cache_Fill_Beat = '0;
    Cache_Fill_Data = '0;
    Mem_Req         = 1'b0;
    Mem_WE          = 1'b0;
    Mem_Addr        = '0;
    Mem_WData       = '0;
    Mem_Mode        = 3'b000;
    beat_clr_s      = 1'b0;
    beat_inc_s      = 1'b0;
    hit_inc_s       = 1'b0;
    miss_inc_s      = 1'b0;
    case (state_q)
      S_IDLE, S_RETRY: begin
        if (!eval_s) begin
          beat_clr_s = 1'b0;
        end else if (Cpu_WE) begin
          Cache_EN_W = Cache_Hit;
          hit_inc_s  = first_s && Cache_Hit;
          miss_inc_s = first_s && !Cache_Hit;
        end else if (Cache_Hit) begin
          Cpu_Done  = 1'b1;
          hit_inc_s = first_s;
        end else begin
          miss_inc_s = first_s;
          beat_clr_s = !Victim_Hit;
        end
      end
      S_SWAP: Cache_Swap = 1'b1;
      S_RD_REQ: begin
        Mem_Req  = 1'b1;
        Mem_Addr = blk_addr_s;
      end
      S_RD_WAIT: begin
        if (Mem_RValid) begin
          Cache_Fill      = 1'b1;
          Cache_Fill_Beat = beat_s;
          Cache_Fill_Data = Mem_RData;
          beat_clr_s      = last_s;
          beat_inc_s      = !last_s;
        end else begin
          Cache_Fill = 1'b0;
        end
      end
      S_WR_REQ: begin
        Mem_Req   = 1'b1;
        Mem_WE    = 1'b1;
        Mem_Addr  = Cpu_Address;
        Mem_WData = Cpu_Data_IN;
        Mem_Mode  = Cpu_Mode;
        Cpu_Done  = Mem_Ack;
      end
      default: Cpu_Done = 1'b0;
    endcase
  end

  assign Cpu_Stall  = Cpu_Req & ~Cpu_Done;
  assign Hit_Count  = hit_q;
  assign Miss_Count = miss_q;

endmodule

// File: tb/tb_cache_miss_controller.sv
// Directed self-checking bench for cache_miss_controller (CntWidth=4 to reach wrap).
module tb_cache_miss_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Cpu_Req, Cpu_WE;
  logic [2:0]  Cpu_Mode;
  logic [31:0] Cpu_Address, Cpu_Data_IN;
  logic        Cpu_Stall, Cpu_Done;
  logic        Cache_Hit, Victim_Hit;
  logic        Cache_EN_W, Cache_Swap, Cache_Fill;
  logic [1:0]  Cache_Fill_Beat;
  logic [31:0] Cache_Fill_Data;
  logic        Mem_Req, Mem_WE;
  logic [31:0] Mem_Addr, Mem_WData;
  logic [2:0]  Mem_Mode;
  logic        Mem_Ack, Mem_RValid;
  logic [31:0] Mem_RData;
  logic [3:0]  Hit_Count, Miss_Count;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  cache_miss_controller #(.Width(32), .BlockSize(16), .CntWidth(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .Cpu_Req(Cpu_Req), .Cpu_WE(Cpu_WE), .Cpu_Mode(Cpu_Mode),
    .Cpu_Address(Cpu_Address), .Cpu_Data_IN(Cpu_Data_IN),
    .Cpu_Stall(Cpu_Stall), .Cpu_Done(Cpu_Done),
    .Cache_Hit(Cache_Hit), .Victim_Hit(Victim_Hit),
    .Cache_EN_W(Cache_EN_W), .Cache_Swap(Cache_Swap), .Cache_Fill(Cache_Fill),
    .Cache_Fill_Beat(Cache_Fill_Beat), .Cache_Fill_Data(Cache_Fill_Data),
    .Mem_Req(Mem_Req), .Mem_WE(Mem_WE), .Mem_Addr(Mem_Addr),
    .Mem_WData(Mem_WData), .Mem_Mode(Mem_Mode),
    .Mem_Ack(Mem_Ack), .Mem_RValid(Mem_RValid), .Mem_RData(Mem_RData),
    .Hit_Count(Hit_Count), .Miss_Count(Miss_Count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One refill beat: a request cycle, a held request acked, then read data.
  task automatic refill_beat(input int b, input logic [31:0] base);
    @(negedge clk); Mem_Ack = 1'b0; Mem_RValid = 1'b0; #1;
    check_eq($sformatf("rd_req%0d", b),  {31'd0, Mem_Req}, 32'd1);
    check_eq($sformatf("rd_we%0d", b),   {31'd0, Mem_WE},  32'd0);
    check_eq($sformatf("rd_addr%0d", b), Mem_Addr, base + 32'(4 * b));
    check_eq($sformatf("rd_stall%0d", b), {31'd0, Cpu_Stall}, 32'd1);
    @(negedge clk); Mem_Ack = 1'b1; #1;
    check_eq($sformatf("rd_hold%0d", b), {31'd0, Mem_Req}, 32'd1);
    @(negedge clk); Mem_Ack = 1'b0; Mem_RValid = 1'b1; Mem_RData = 32'hA0 + 32'(b); #1;
    check_eq($sformatf("fill%0d", b),      {31'd0, Cache_Fill}, 32'd1);
    check_eq($sformatf("fill_beat%0d", b), {30'd0, Cache_Fill_Beat}, 32'(b));
    check_eq($sformatf("fill_data%0d", b), Cache_Fill_Data, 32'hA0 + 32'(b));
    check_eq($sformatf("fill_stall%0d", b), {31'd0, Cpu_Stall}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; Cpu_Req = 1'b0; Cpu_WE = 1'b0; Cpu_Mode = 3'b010;
    Cpu_Address = 32'd0; Cpu_Data_IN = 32'd0; Cache_Hit = 1'b0; Victim_Hit = 1'b0;
    Mem_Ack = 1'b0; Mem_RValid = 1'b0; Mem_RData = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_hits",  {28'd0, Hit_Count},  32'd0);
    check_eq("rst_miss",  {28'd0, Miss_Count}, 32'd0);
    check_eq("rst_memreq", {31'd0, Mem_Req},   32'd0);
    check_eq("rst_stall", {31'd0, Cpu_Stall},  32'd0);
    rst_n = 1'b1;

    // Zero-stall load hit
    @(negedge clk); Cpu_Req = 1'b1; Cpu_Address = 32'h0000_0100; Cache_Hit = 1'b1; #1;
    check_eq("lh_done",  {31'd0, Cpu_Done},  32'd1);
    check_eq("lh_stall", {31'd0, Cpu_Stall}, 32'd0);
    check_eq("lh_memreq", {31'd0, Mem_Req},  32'd0);
    @(negedge clk); Cpu_Req = 1'b0; Cache_Hit = 1'b0; #1;
    check_eq("lh_count", {28'd0, Hit_Count}, 32'd1);

    // Victim swap
    @(negedge clk); Cpu_Req = 1'b1; Cpu_Address = 32'h0000_1234; Victim_Hit = 1'b1; #1;
    check_eq("vh_c1_done",  {31'd0, Cpu_Done},   32'd0);
    check_eq("vh_c1_stall", {31'd0, Cpu_Stall},  32'd1);
    check_eq("vh_c1_swap",  {31'd0, Cache_Swap}, 32'd0);
    @(negedge clk); Victim_Hit = 1'b0; #1;
    check_eq("vh_c2_swap",  {31'd0, Cache_Swap}, 32'd1);
    check_eq("vh_c2_stall", {31'd0, Cpu_Stall},  32'd1);
    @(negedge clk); Cache_Hit = 1'b1; #1;
    check_eq("vh_c3_done",  {31'd0, Cpu_Done},   32'd1);
    check_eq("vh_c3_swap",  {31'd0, Cache_Swap}, 32'd0);
    check_eq("vh_miss",     {28'd0, Miss_Count}, 32'd1);
    @(negedge clk); Cpu_Req = 1'b0; Cache_Hit = 1'b0; #1;
    check_eq("vh_hits", {28'd0, Hit_Count}, 32'd1);

    // Memory refill of block 0x1230
    @(negedge clk); Cpu_Req = 1'b1; Cpu_Address = 32'h0000_1238; #1;
    check_eq("rf_stall0", {31'd0, Cpu_Stall}, 32'd1);
    for (int b = 0; b < 4; b++) refill_beat(b, 32'h0000_1230);
    @(negedge clk); Mem_RValid = 1'b0; Cache_Hit = 1'b1; #1;
    check_eq("rf_retry_done", {31'd0, Cpu_Done}, 32'd1);
    check_eq("rf_retry_fill", {31'd0, Cache_Fill}, 32'd0);
    @(negedge clk); Cpu_Req = 1'b0; Cache_Hit = 1'b0; #1;
    check_eq("rf_miss", {28'd0, Miss_Count}, 32'd2);
    check_eq("rf_hits", {28'd0, Hit_Count},  32'd1);

    // Store hit, write-through
    @(negedge clk); Cpu_Req = 1'b1; Cpu_WE = 1'b1; Cpu_Mode = 3'b111;
    Cpu_Address = 32'h0000_0040; Cpu_Data_IN = 32'hDEAD_BEEF; Cache_Hit = 1'b1; #1;
    check_eq("sh_enw",   {31'd0, Cache_EN_W}, 32'd1);
    check_eq("sh_stall", {31'd0, Cpu_Stall},  32'd1);
    @(negedge clk); Cache_Hit = 1'b0; #1;
    check_eq("sh_memreq", {31'd0, Mem_Req}, 32'd1);
    check_eq("sh_memwe",  {31'd0, Mem_WE},  32'd1);
    check_eq("sh_addr",   Mem_Addr,  32'h0000_0040);
    check_eq("sh_wdata",  Mem_WData, 32'hDEAD_BEEF);
    check_eq("sh_mode",   {29'd0, Mem_Mode}, 32'd7);
    check_eq("sh_enw2",   {31'd0, Cache_EN_W}, 32'd0);
    check_eq("sh_done0",  {31'd0, Cpu_Done}, 32'd0);
    @(negedge clk); Mem_Ack = 1'b1; #1;
    check_eq("sh_done",  {31'd0, Cpu_Done},  32'd1);
    check_eq("sh_stall2", {31'd0, Cpu_Stall}, 32'd0);
    @(negedge clk); Cpu_Req = 1'b0; Mem_Ack = 1'b0; #1;
    check_eq("sh_hits", {28'd0, Hit_Count}, 32'd2);
    check_eq("sh_mode_idle", {29'd0, Mem_Mode}, 32'd0);

    // Store miss: cache untouched, same memory write
    @(negedge clk); Cpu_Req = 1'b1; #1;
    check_eq("sm_enw", {31'd0, Cache_EN_W}, 32'd0);
    @(negedge clk); Mem_Ack = 1'b1; #1;
    check_eq("sm_addr",  Mem_Addr,  32'h0000_0040);
    check_eq("sm_wdata", Mem_WData, 32'hDEAD_BEEF);
    check_eq("sm_mode",  {29'd0, Mem_Mode}, 32'd7);
    check_eq("sm_done",  {31'd0, Cpu_Done}, 32'd1);
    @(negedge clk); Cpu_Req = 1'b0; Mem_Ack = 1'b0; Cpu_WE = 1'b0; Cpu_Mode = 3'b010; #1;
    check_eq("sm_miss", {28'd0, Miss_Count}, 32'd3);

    // Reset in RD_WAIT of beat 2, then a late read-valid
    @(negedge clk); Cpu_Req = 1'b1; Cpu_Address = 32'h0000_2008;
    refill_beat(0, 32'h0000_2000);
    refill_beat(1, 32'h0000_2000);
    @(negedge clk); Mem_RValid = 1'b0;
    @(negedge clk); Mem_Ack = 1'b1;
    @(negedge clk); Mem_Ack = 1'b0; Mem_RValid = 1'b1; Mem_RData = 32'hA2; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; Cpu_Req = 1'b0; #1;
    check_eq("rr_fill",  {31'd0, Cache_Fill}, 32'd0);
    check_eq("rr_memreq", {31'd0, Mem_Req},   32'd0);
    check_eq("rr_done",  {31'd0, Cpu_Done},   32'd0);
    check_eq("rr_hits",  {28'd0, Hit_Count},  32'd0);
    check_eq("rr_miss",  {28'd0, Miss_Count}, 32'd0);
    @(negedge clk); Mem_RValid = 1'b0; #1;
    check_eq("rr_fill2", {31'd0, Cache_Fill}, 32'd0);

    // Fresh refill after reset must start from beat 0
    @(negedge clk); Cpu_Req = 1'b1; Cpu_Address = 32'h0000_300C;
    for (int b = 0; b < 4; b++) refill_beat(b, 32'h0000_3000);
    @(negedge clk); Mem_RValid = 1'b0; Cache_Hit = 1'b1; #1;
    check_eq("r2_done", {31'd0, Cpu_Done}, 32'd1);
    @(negedge clk); Cpu_Req = 1'b0; Cache_Hit = 1'b0; #1;
    check_eq("r2_miss", {28'd0, Miss_Count}, 32'd1);

    // 16 back-to-back load hits wrap the 4-bit counter
    @(negedge clk); Cpu_Req = 1'b1; Cache_Hit = 1'b1; Cpu_Address = 32'h0000_0200;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk); #1;
      check_eq($sformatf("wrap%0d", i), {28'd0, Hit_Count}, 32'(i % 16));
    end
    Cpu_Req = 1'b0; Cache_Hit = 1'b0;
    check_eq("wrap_miss", {28'd0, Miss_Count}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
